// File: rtl/regfile_multiport_pkg.sv
// Shared defaults and helpers for the multi-port CPU register file.
package cpu_rf_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_NUM_REGS = 16;

    // R0 has its own write port (mul/div unit) and its own read output.
    localparam int R0_ADDR = 0;

    // Address width needed to select one of num_regs registers.
    function automatic int rf_aw(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle between the ID stage (master) and the register file (slave).
interface regfile_multiport_if
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2
);

    localparam int AW = rf_aw(NUM_REGS);

    // Read side: packed per-port addresses and data, plus the R0 view.
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]        reg0_data;

    // General writeback port.
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;

    // Dedicated mul/div port into R0.
    logic                     r0_wr_en;
    logic [DATA_W-1:0]        r0_wr_data;

    // One-cycle pulse after both ports targeted R0 together.
    logic                     wr_conflict;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, r0_wr_en, r0_wr_data,
        input  rd_data, reg0_data, wr_conflict
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, r0_wr_en, r0_wr_data,
        output rd_data, reg0_data, wr_conflict
    );

endinterface

// File: rtl/regfile_bypass_mux.sv
// Resolves one read value: stored contents, optionally overridden by a
// same-cycle write. The R0 port wins over the general port for address 0.
module regfile_bypass_mux
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int AW     = rf_aw(DEFAULT_NUM_REGS),
    parameter int BYPASS = 1
) (
    input  logic [DATA_W-1:0] stored_data,
    input  logic [AW-1:0]     rd_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              r0_wr_en,
    input  logic [DATA_W-1:0] r0_wr_data,
    output logic [DATA_W-1:0] rd_data
);

    // Forwarding priority: r0 port, then general port, then storage.
    always_comb begin
        rd_data = stored_data;
        if (BYPASS != 0) begin
            if (wr_en && (rd_addr == wr_addr)) begin
                rd_data = wr_data;
            end
            if (r0_wr_en && (rd_addr == AW'(R0_ADDR))) begin
                rd_data = r0_wr_data;
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised ID-stage register file: NUM_RD read ports, a general write
// port, a dedicated R0 write port, optional bypass and optional read register.
module regfile_multiport
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    regfile_multiport_if.slave  rf
);

    localparam int AW = rf_aw(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_conflict_q;
    logic              wr_conflict_d;

    // Forwarding is suppressed while reset is held so outputs stay at zero.
    logic              fwd_wr_en;
    logic              fwd_r0_wr_en;

    logic [NUM_RD*DATA_W-1:0] rd_resolved;
    logic [DATA_W-1:0]        reg0_resolved;

    assign fwd_wr_en    = rf.wr_en    & reset_n;
    assign fwd_r0_wr_en = rf.r0_wr_en & reset_n;

    // Next register contents; the R0 port is applied last so it wins on R0.
    always_comb begin
        regs_d = regs_q;
        if (rf.wr_en) begin
            regs_d[rf.wr_addr] = rf.wr_data;
        end
        if (rf.r0_wr_en) begin
            regs_d[R0_ADDR] = rf.r0_wr_data;
        end
    end

    // Both ports aimed at R0 in the same cycle: general write was dropped.
    always_comb begin
        wr_conflict_d = rf.wr_en && rf.r0_wr_en && (rf.wr_addr == AW'(R0_ADDR));
    end

    // Register storage and conflict flag; reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign rf.wr_conflict = wr_conflict_q;

    // One resolver per general read port.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
        logic [AW-1:0] port_addr;
        assign port_addr = rf.rd_addr[k*AW +: AW];

        regfile_bypass_mux #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_mux (
            .stored_data (regs_q[port_addr]),
            .rd_addr     (port_addr),
            .wr_en       (fwd_wr_en),
            .wr_addr     (rf.wr_addr),
            .wr_data     (rf.wr_data),
            .r0_wr_en    (fwd_r0_wr_en),
            .r0_wr_data  (rf.r0_wr_data),
            .rd_data     (rd_resolved[k*DATA_W +: DATA_W])
        );
    end

    // Dedicated R0 view uses the same forwarding rules.
    regfile_bypass_mux #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_reg0_mux (
        .stored_data (regs_q[R0_ADDR]),
        .rd_addr     (AW'(R0_ADDR)),
        .wr_en       (fwd_wr_en),
        .wr_addr     (rf.wr_addr),
        .wr_data     (rf.wr_data),
        .r0_wr_en    (fwd_r0_wr_en),
        .r0_wr_data  (rf.r0_wr_data),
        .rd_data     (reg0_resolved)
    );

    if (READ_LAT == 1) begin : g_read_reg
        logic [NUM_RD*DATA_W-1:0] rd_data_q;
        logic [NUM_RD*DATA_W-1:0] rd_data_d;
        logic [DATA_W-1:0]        reg0_data_q;
        logic [DATA_W-1:0]        reg0_data_d;

        // Capture the resolved value at the same edge that commits writes.
        always_comb begin
            rd_data_d   = rd_resolved;
            reg0_data_d = reg0_resolved;
        end

        // Output register stage, cleared asynchronously with the file.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_data_q   <= '0;
                reg0_data_q <= '0;
            end else begin
                rd_data_q   <= rd_data_d;
                reg0_data_q <= reg0_data_d;
            end
        end

        assign rf.rd_data   = rd_data_q;
        assign rf.reg0_data = reg0_data_q;
    end else begin : g_read_comb
        assign rf.rd_data   = rd_resolved;
        assign rf.reg0_data = reg0_resolved;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: three configurations driven in lockstep
// (no bypass / bypass / bypass + registered read) against a reference model.
module tb_regfile_multiport;

    logic clk;
    logic reset_n;

    logic [3:0]  a0, a1;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        r0_wr_en;
    logic [15:0] r0_wr_data;

    regfile_multiport_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2)) if_a ();
    regfile_multiport_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2)) if_b ();
    regfile_multiport_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2)) if_c ();

    assign if_a.rd_addr = {a1, a0};
    assign if_a.wr_en = wr_en;
    assign if_a.wr_addr = wr_addr;
    assign if_a.wr_data = wr_data;
    assign if_a.r0_wr_en = r0_wr_en;
    assign if_a.r0_wr_data = r0_wr_data;
    assign if_b.rd_addr = {a1, a0};
    assign if_b.wr_en = wr_en;
    assign if_b.wr_addr = wr_addr;
    assign if_b.wr_data = wr_data;
    assign if_b.r0_wr_en = r0_wr_en;
    assign if_b.r0_wr_data = r0_wr_data;
    assign if_c.rd_addr = {a1, a0};
    assign if_c.wr_en = wr_en;
    assign if_c.wr_addr = wr_addr;
    assign if_c.wr_data = wr_data;
    assign if_c.r0_wr_en = r0_wr_en;
    assign if_c.r0_wr_data = r0_wr_data;

    regfile_multiport #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .BYPASS(0), .READ_LAT(0))
        dut_a (.clk(clk), .reset_n(reset_n), .rf(if_a));
    regfile_multiport #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .BYPASS(1), .READ_LAT(0))
        dut_b (.clk(clk), .reset_n(reset_n), .rf(if_b));
    regfile_multiport #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .BYPASS(1), .READ_LAT(1))
        dut_c (.clk(clk), .reset_n(reset_n), .rf(if_c));

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] m_regs [16];
    logic        exp_conflict;
    logic [47:0] exp_q [$];   // {reg0, rd1, rd0} expected from the registered DUT

    task automatic check_vec(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] a, input logic fwd);
        if (fwd && r0_wr_en && a == 4'd0) return r0_wr_data;
        else if (fwd && wr_en && wr_addr == a) return wr_data;
        else return m_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        exp_conflict = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_conflicts();
        check_vec("conflict_a", {47'd0, if_a.wr_conflict}, {47'd0, exp_conflict});
        check_vec("conflict_b", {47'd0, if_b.wr_conflict}, {47'd0, exp_conflict});
        check_vec("conflict_c", {47'd0, if_c.wr_conflict}, {47'd0, exp_conflict});
    endtask

    // ---------------- driver ----------------
    // One clock cycle: check registered outputs from the previous cycle,
    // drive new inputs, check combinational outputs, then advance the model.
    task automatic cycle(input logic wen, input logic [3:0] wa, input logic [15:0] wd,
                         input logic r0en, input logic [15:0] r0d,
                         input logic [3:0] ra0, input logic [3:0] ra1);
        logic [47:0] raw_v;
        logic [47:0] fwd_v;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            check_vec("lat1_rd", {if_c.reg0_data, if_c.rd_data}, exp_q.pop_front());
        end
        check_conflicts();
        wr_en = wen; wr_addr = wa; wr_data = wd;
        r0_wr_en = r0en; r0_wr_data = r0d;
        a0 = ra0; a1 = ra1;
        #2;
        raw_v = {model_read(4'd0, 1'b0), model_read(ra1, 1'b0), model_read(ra0, 1'b0)};
        fwd_v = {model_read(4'd0, 1'b1), model_read(ra1, 1'b1), model_read(ra0, 1'b1)};
        check_vec("nobyp_rd", {if_a.reg0_data, if_a.rd_data}, raw_v);
        check_vec("byp_rd", {if_b.reg0_data, if_b.rd_data}, fwd_v);
        exp_q.push_back(fwd_v);
        exp_conflict = wen && r0en && (wa == 4'd0);
        if (wen) m_regs[wa] = wd;
        if (r0en) m_regs[0] = r0d;
    endtask

    task automatic check_all_zero(input string tag);
        check_vec({tag, "_a"}, {if_a.reg0_data, if_a.rd_data}, 48'd0);
        check_vec({tag, "_b"}, {if_b.reg0_data, if_b.rd_data}, 48'd0);
        check_vec({tag, "_c"}, {if_c.reg0_data, if_c.rd_data}, 48'd0);
        check_vec({tag, "_cf"}, {45'd0, if_a.wr_conflict, if_b.wr_conflict, if_c.wr_conflict}, 48'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0;
        r0_wr_en = 1'b0; r0_wr_data = 16'h0;
        a0 = 4'd0; a1 = 4'd1;
        model_clear();

        // Reset held for 20 ns, outputs checked while held.
        #3;
        check_all_zero("in_reset");
        #17;
        reset_n = 1'b1;
        #1;
        check_all_zero("post_reset");

        // Every address reads zero after reset.
        for (int i = 0; i < 16; i++) cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'(i), 4'(15 - i));

        // Write R3, same-cycle read sees old value without bypass, new with.
        cycle(1'b1, 4'd3, 16'hBEEF, 1'b0, 16'h0, 4'd3, 4'd0);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd3, 4'd3);

        // Bypass on port 1.
        cycle(1'b1, 4'd5, 16'h1234, 1'b0, 16'h0, 4'd0, 4'd5);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd5, 4'd3);

        // R0 conflict: mul/div wins, flag for exactly one cycle.
        cycle(1'b1, 4'd0, 16'hAAAA, 1'b1, 16'h5555, 4'd0, 4'd0);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd0, 4'd5);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd0, 4'd0);

        // Both ports active on different registers commit independently.
        cycle(1'b1, 4'd9, 16'h0909, 1'b1, 16'h7777, 4'd9, 4'd0);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd9, 4'd0);

        // General port writing R0 alone; then registered read latency on R7.
        cycle(1'b1, 4'd0, 16'h0F0F, 1'b0, 16'h0, 4'd1, 4'd0);
        cycle(1'b1, 4'd7, 16'h00FF, 1'b0, 16'h0, 4'd1, 4'd1);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd7, 4'd1);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd7, 4'd7);

        // Random traffic, biased toward R0 so conflicts occur.
        for (int n = 0; n < 60; n++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15)),
                  16'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) == 0),
                  16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Put known data in R2 and leave the registered port showing it.
        cycle(1'b1, 4'd2, 16'h1111, 1'b1, 16'h2222, 4'd2, 4'd0);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd2, 4'd2);

        // Asynchronous reset between edges while writing R2.
        @(negedge clk);
        check_vec("pre_rst_c", {if_c.reg0_data, if_c.rd_data}, exp_q.pop_front());
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hCAFE;
        r0_wr_en = 1'b0; a0 = 4'd2; a1 = 4'd2;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_edge");
        @(negedge clk);
        wr_en = 1'b0;
        model_clear();
        reset_n = 1'b1;
        #1;
        check_all_zero("rerelease");
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd2, 4'd0);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd2, 4'd2);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 4'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
